clock_edge_monitor: RTL and testbench



---
 rtl/clock_edge_monitor.sv | 167 ++++++++++++++++
 tb/tb_clock_edge_monitor.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/clock_edge_monitor.sv
// Synchronises a slow clock-like input into i_clock, emits rise/fall strobes, measures the
// half-period and tracks lock/loss of that measurement.
module clock_edge_monitor #(
    parameter int unsigned NB_COUNT   = 16,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_clk_in,
    output logic                o_rise,
    output logic                o_fall,
    output logic [NB_COUNT-1:0] o_half_period,
    output logic                o_meas_valid,
    output logic                o_locked,
    output logic                o_lost
);

    localparam int unsigned MW = $clog2(LOCK_COUNT + 1);

    localparam logic [MW-1:0]       LockVal    = MW'(LOCK_COUNT);
    localparam logic [MW-1:0]       MatchOne   = MW'(1);
    localparam logic [NB_COUNT-1:0] TimeoutVal = NB_COUNT'(TIMEOUT);
    localparam logic [NB_COUNT-1:0] CntOne     = NB_COUNT'(1);
    localparam logic [NB_COUNT-1:0] CntMax     = '1;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StAcquire = 2'd1;
    localparam logic [1:0] StLocked  = 2'd2;
    localparam logic [1:0] StLost    = 2'd3;

    logic                s1_q, s2_q, s3_q;
    logic                rise_q, fall_q;
    logic [NB_COUNT-1:0] cnt_q, cnt_d;
    logic [NB_COUNT-1:0] ref_q, ref_d;
    logic [MW-1:0]       match_q, match_d;
    logic [NB_COUNT-1:0] half_q, half_d;
    logic                valid_q, valid_d;
    logic                locked_q, locked_d;
    logic                lost_q, lost_d;
    logic [1:0]          state_q, state_d;

    logic                edge_r, edge_f, edge_any, timeout;
    logic [NB_COUNT-1:0] meas;

    always_comb begin
        edge_r   = s2_q & ~s3_q;
        edge_f   = ~s2_q & s3_q;
        edge_any = edge_r | edge_f;
        timeout  = (cnt_q == TimeoutVal);
        meas     = cnt_q;

        // Counter restarts at 1 so that a half-period of H cycles measures exactly H.
        if (edge_any) begin
            cnt_d = CntOne;
        end else if (cnt_q == CntMax) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CntOne;
        end

        state_d  = state_q;
        ref_d    = ref_q;
        match_d  = match_q;
        half_d   = half_q;
        valid_d  = valid_q;
        locked_d = locked_q;
        lost_d   = lost_q;

        case (state_q)
            StIdle: begin
                if (edge_any) begin
                    state_d = StAcquire;
                end else if (timeout) begin
                    state_d = StLost;
                    lost_d  = 1'b1;
                    match_d = '0;
                end
            end
            StAcquire: begin
                if (edge_any) begin
                    half_d  = meas;
                    valid_d = 1'b1;
                    if (match_q == '0 || meas != ref_q) begin
                        ref_d   = meas;
                        match_d = MatchOne;
                    end else if (match_q != LockVal) begin
                        match_d = match_q + MatchOne;
                    end
                    if (match_d == LockVal) begin
                        state_d  = StLocked;
                        locked_d = 1'b1;
                    end
                end else if (timeout) begin
                    state_d  = StLost;
                    lost_d   = 1'b1;
                    locked_d = 1'b0;
                    match_d  = '0;
                end
            end
            StLocked: begin
                if (edge_any) begin
                    half_d = meas;
                    if (meas != ref_q) begin
                        state_d  = StAcquire;
                        locked_d = 1'b0;
                        ref_d    = meas;
                        match_d  = MatchOne;
                    end
                end else if (timeout) begin
                    state_d  = StLost;
                    lost_d   = 1'b1;
                    locked_d = 1'b0;
                    match_d  = '0;
                end
            end
            StLost: begin
                // The edge ending a loss carries a stale count, so it is not a measurement.
                if (edge_any) begin
                    state_d = StAcquire;
                    lost_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            cnt_q    <= '0;
            ref_q    <= '0;
            match_q  <= '0;
            half_q   <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            lost_q   <= 1'b0;
            state_q  <= StIdle;
        end else begin
            s1_q     <= i_clk_in;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            rise_q   <= edge_r;
            fall_q   <= edge_f;
            cnt_q    <= cnt_d;
            ref_q    <= ref_d;
            match_q  <= match_d;
            half_q   <= half_d;
            valid_q  <= valid_d;
            locked_q <= locked_d;
            lost_q   <= lost_d;
            state_q  <= state_d;
        end
    end

    assign o_rise        = rise_q;
    assign o_fall        = fall_q;
    assign o_half_period = half_q;
    assign o_meas_valid  = valid_q;
    assign o_locked      = locked_q;
    assign o_lost        = lost_q;

endmodule

// File: tb/tb_clock_edge_monitor.sv
// Bench for clock_edge_monitor: strobe scoreboard on a default-sized instance, directed
// timeout/saturation/priority checks on a small instance (NB_COUNT=4, TIMEOUT=10).
module tb_clock_edge_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst, clk_in, rise, fall, valid, locked, lost;
    logic [15:0] half;
    logic        rst2, clk_in2, rise2, fall2, valid2, locked2, lost2;
    logic [3:0]  half2;

    clock_edge_monitor #(.NB_COUNT(16), .LOCK_COUNT(4), .TIMEOUT(1024)) dut (
        .i_clock(clk), .i_reset(rst), .i_clk_in(clk_in), .o_rise(rise), .o_fall(fall),
        .o_half_period(half), .o_meas_valid(valid), .o_locked(locked), .o_lost(lost)
    );

    clock_edge_monitor #(.NB_COUNT(4), .LOCK_COUNT(4), .TIMEOUT(10)) dut_small (
        .i_clock(clk), .i_reset(rst2), .i_clk_in(clk_in2), .o_rise(rise2), .o_fall(fall2),
        .o_half_period(half2), .o_meas_valid(valid2), .o_locked(locked2), .o_lost(lost2)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        rise;
        logic [15:0] half;
        logic        valid;
        logic        locked;
        logic        lost;
        logic [31:0] cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_exp, mon_got;

    // Monitor: every strobe pops one expectation, including the cycle it must appear in.
    always @(negedge clk) begin
        if (rise && fall) begin
            checks++;
            errors++;
            $display("FAIL strobe_overlap: got rise=1 fall=1 at cyc %0d, required one-hot", cyc);
        end else if (rise || fall) begin
            checks++;
            mon_got.rise   = rise;
            mon_got.half   = half;
            mon_got.valid  = valid;
            mon_got.locked = locked;
            mon_got.lost   = lost;
            mon_got.cyc    = cyc;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got rise=%0b at cyc %0d, required none",
                         rise, cyc);
            end else begin
                mon_exp = sb_q.pop_front();
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display({"FAIL strobe: got rise=%0b half=%0d valid=%0b locked=%0b lost=%0b",
                              " cyc=%0d required rise=%0b half=%0d valid=%0b locked=%0b lost=%0b",
                              " cyc=%0d"},
                             mon_got.rise, mon_got.half, mon_got.valid, mon_got.locked,
                             mon_got.lost, mon_got.cyc, mon_exp.rise, mon_exp.half,
                             mon_exp.valid, mon_exp.locked, mon_exp.lost, mon_exp.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Toggle the main input after gap cycles; its strobe is due 3 cycles after the toggle.
    task automatic flip(input int unsigned gap, input logic [15:0] h, input logic v,
                        input logic l, input logic lo);
        exp_t e;
        repeat (gap) @(posedge clk);
        #1 clk_in = ~clk_in;
        e.rise   = clk_in;
        e.half   = h;
        e.valid  = v;
        e.locked = l;
        e.lost   = lo;
        e.cyc    = 32'(cyc + 3);
        sb_q.push_back(e);
    endtask

    task automatic wait_to(input int unsigned target);
        do @(negedge clk); while (cyc < target);
    endtask

    task automatic flip2_at(input int unsigned target);
        do begin
            @(posedge clk);
            #1;
        end while (cyc < target);
        clk_in2 = ~clk_in2;
    endtask

    int unsigned last, r, c0, c1;

    initial begin
        rst = 1'b1; clk_in = 1'b0; rst2 = 1'b1; clk_in2 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {rise, fall, half, valid, locked, lost}, 32'd0);
        check("reset_outputs_small", {rise2, fall2, half2, valid2, locked2, lost2}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Half-period 4: first edge discarded, valid from the 2nd, lock after the 5th.
        flip(3, 16'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) flip(4, 16'd4, 1'b1, 1'b0, 1'b0);
        repeat (4) flip(4, 16'd4, 1'b1, 1'b1, 1'b0);

        // Half-period 2: unlock on first differing measurement, relock on the 4th equal one.
        repeat (3) flip(2, 16'd2, 1'b1, 1'b0, 1'b0);
        repeat (2) flip(2, 16'd2, 1'b1, 1'b1, 1'b0);
        repeat (3) flip(4, 16'd4, 1'b1, 1'b0, 1'b0);
        flip(4, 16'd4, 1'b1, 1'b1, 1'b0);

        // Stop toggling: loss declared 1027 cycles after the final toggle.
        last = cyc;
        wait_to(last + 1026);
        check("pre_timeout_lost", {31'd0, lost}, 32'd0);
        check("pre_timeout_locked", {31'd0, locked}, 32'd1);
        wait_to(last + 1027);
        check("timeout_lost", {31'd0, lost}, 32'd1);
        check("timeout_locked", {31'd0, locked}, 32'd0);
        check("timeout_half_held", {16'd0, half}, 32'd4);
        check("timeout_valid_held", {31'd0, valid}, 32'd1);

        flip(5, 16'd4, 1'b1, 1'b0, 1'b0);
        repeat (3) flip(4, 16'd4, 1'b1, 1'b0, 1'b0);
        repeat (3) flip(4, 16'd4, 1'b1, 1'b1, 1'b0);

        // One-cycle reset while locked with the input low.
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrun_reset_outputs", {rise, fall, half, valid, locked, lost}, 32'd0);
        repeat (10) @(posedge clk);
        flip(1, 16'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) flip(4, 16'd4, 1'b1, 1'b0, 1'b0);
        flip(4, 16'd4, 1'b1, 1'b1, 1'b0);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        // Small instance: input stuck low from reset, timeout at cnt==10.
        @(posedge clk);
        #1 rst2 = 1'b0;
        r = cyc;
        wait_to(r + 10);
        check("small_pre_timeout_lost", {31'd0, lost2}, 32'd0);
        wait_to(r + 11);
        check("small_timeout_lost", {31'd0, lost2}, 32'd1);
        check("small_timeout_valid", {31'd0, valid2}, 32'd0);
        wait_to(r + 30);
        check("small_lost_held", {31'd0, lost2}, 32'd1);

        // Edge while lost: clears loss, measurement discarded.
        @(posedge clk);
        #1 clk_in2 = 1'b1;
        c0 = cyc;
        wait_to(c0 + 3);
        check("small_lost_edge_rise", {30'd0, rise2, fall2}, 32'd2);
        check("small_lost_edge_state", {half2, valid2, locked2, lost2}, 32'd0);
        wait_to(c0 + 4);
        check("small_strobe_width", {30'd0, rise2, fall2}, 32'd0);

        // Half-period 20 exceeds TIMEOUT: loss fires at 10 rather than saturating.
        wait_to(c0 + 12);
        check("small_acq_pre_timeout", {31'd0, lost2}, 32'd0);
        wait_to(c0 + 13);
        check("small_acq_timeout", {half2, valid2, locked2, lost2}, 32'd1);

        // Edge coinciding with cnt==TIMEOUT: the edge wins and measures 10.
        flip2_at(c0 + 20);
        c1 = cyc;
        wait_to(c1 + 3);
        check("small_second_lost_edge", {half2, valid2, locked2, lost2}, 32'd0);
        flip2_at(c1 + 10);
        wait_to(c1 + 13);
        check("small_edge_vs_timeout_rise", {30'd0, rise2, fall2}, 32'd2);
        check("small_edge_vs_timeout", {half2, valid2, locked2, lost2}, {25'd0, 4'd10, 3'b100});
        flip2_at(c1 + 20);
        wait_to(c1 + 23);
        check("small_repeat_meas", {half2, valid2, locked2, lost2}, {25'd0, 4'd10, 3'b100});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
